// File: rtl/watch_set_ctrl.sv
// Time-set controller for the HH:MM watch counter: debounce, RUN/SET_HR/SET_MIN/COMMIT editing, blink and load strobe.
// Optional feature macro: AUTO_REPEAT_EN (button3 hold auto-repeat on tick_1hz after REP_DELAY ticks).
module watch_set_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int BLINK_DIV  = 8
`ifdef AUTO_REPEAT_EN
  , parameter int REP_DELAY = 2
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       switch,
  input  logic       button2,
  input  logic       button3,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       count_en,
  output logic       ld_valid,
  output logic [4:0] ld_hours,
  output logic [5:0] ld_minutes,
  output logic       blink_hr,
  output logic       blink_min
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN, COMMIT} state_t;

  state_t        state;
  logic [2:0]    raw, sync1, sync2, deb, upd;
  logic [DW-1:0] deb_cnt [3];
  logic          sw_rise, sw_fall, b2_rise, b3_rise, rep_fire, bump, blink_wrap;
  logic [4:0]    shadow_h;
  logic [5:0]    shadow_m;
  logic          blink_phase;
  logic [BW-1:0] blink_cnt;

  assign raw = {button3, button2, switch};

  // A level update fires on the same edge the FSM sees its event, so total latency is DEB_CYCLES+2.
  always_comb begin
    upd = '0;
    for (int i = 0; i < 3; i++)
      upd[i] = (sync2[i] != deb[i]) && (deb_cnt[i] == DW'(DEB_CYCLES - 1));
  end

  assign sw_rise    = upd[0] & sync2[0];
  assign sw_fall    = upd[0] & ~sync2[0];
  assign b2_rise    = upd[1] & sync2[1];
  assign b3_rise    = upd[2] & sync2[2];
  assign bump       = b3_rise | rep_fire;
  assign blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (upd[i]) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int HW = $clog2(REP_DELAY + 2);
  logic [HW-1:0] hold_cnt;
  logic          in_set;

  assign in_set   = (state == SET_HR) || (state == SET_MIN);
  assign rep_fire = tick_1hz && deb[2] && in_set && (hold_cnt == HW'(REP_DELAY));

  // Hold counter saturates at REP_DELAY; any release or state change restarts the delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hold_cnt <= '0;
    else if (!deb[2] || !in_set || sw_fall || b2_rise)
      hold_cnt <= '0;
    else if (tick_1hz && (hold_cnt != HW'(REP_DELAY)))
      hold_cnt <= hold_cnt + 1'b1;
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Priority inside a set state: switch falling, then button2, then increments; losers are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      count_en    <= 1'b1;
      ld_valid    <= 1'b0;
      ld_hours    <= '0;
      ld_minutes  <= '0;
      blink_hr    <= 1'b0;
      blink_min   <= 1'b0;
      shadow_h    <= '0;
      shadow_m    <= '0;
      blink_phase <= 1'b0;
      blink_cnt   <= '0;
    end else begin
      ld_valid <= 1'b0;
      case (state)
        RUN: begin
          count_en  <= 1'b1;
          blink_hr  <= 1'b0;
          blink_min <= 1'b0;
          if (sw_rise) begin
            shadow_h    <= cur_hours;
            shadow_m    <= cur_minutes;
            state       <= SET_HR;
            count_en    <= 1'b0;
            blink_phase <= 1'b1;
            blink_cnt   <= '0;
            blink_hr    <= 1'b1;
          end
        end
        SET_HR, SET_MIN: begin
          if (sw_fall) begin
            state      <= COMMIT;
            ld_valid   <= 1'b1;
            ld_hours   <= shadow_h;
            ld_minutes <= shadow_m;
            blink_hr   <= 1'b0;
            blink_min  <= 1'b0;
          end else if (b2_rise) begin
            state       <= (state == SET_HR) ? SET_MIN : SET_HR;
            blink_phase <= 1'b1;
            blink_cnt   <= '0;
            blink_hr    <= (state == SET_MIN);
            blink_min   <= (state == SET_HR);
          end else begin
            if (bump) begin
              if (state == SET_HR)
                shadow_h <= (shadow_h == 5'd23) ? 5'd0 : shadow_h + 5'd1;
              else
                shadow_m <= (shadow_m == 6'd59) ? 6'd0 : shadow_m + 6'd1;
            end
            if (tick_1hz) begin
              if (blink_wrap) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
                blink_hr    <= (state == SET_HR) & ~blink_phase;
                blink_min   <= (state == SET_MIN) & ~blink_phase;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
            end
          end
        end
        COMMIT: begin
          state    <= RUN;
          count_en <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
